// File: rtl/rv32i_bus_pkg.sv
// Shared encodings and widths for the RV32I core-to-memory arbiter.
package rv32i_bus_pkg;

    localparam int XLEN     = 32;
    localparam int BE_W     = 4;
    localparam int STARVE_W = 4;
    localparam int TMO_W    = 10;

    localparam logic [BE_W-1:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
// The arbiter takes the master view; the core and memory together form the slave side.
interface rv32i_mem_arbiter_if;
    import rv32i_bus_pkg::*;

    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;

    logic            d_req;
    logic            d_we;
    logic [BE_W-1:0] d_be;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            bus_err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/rv32i_prio_select.sv
// Data-over-fetch priority with a starvation guard that forces a fetch grant
// once the data port has won STARVE_MAX times in a row against a waiting fetch.
module rv32i_prio_select
    import rv32i_bus_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                i_req_i,
    input  logic                d_req_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output logic                grant_i_o,
    output logic                grant_d_o
);

    logic fetchStarved;

    assign fetchStarved = i_req_i && (starve_cnt_i == STARVE_W'(STARVE_MAX));
    assign grant_d_o    = d_req_i && !fetchStarved;
    assign grant_i_o    = i_req_i && !grant_d_o;

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports,
// one transaction outstanding, with a response timeout and sticky bus error.
module rv32i_mem_arbiter
    import rv32i_bus_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk_in,
    input  logic                reset,
    rv32i_mem_arbiter_if.master bus
);

    arb_state_e          state_q;
    owner_e              owner_q;
    logic [STARVE_W-1:0] starveCnt_q;
    logic [TMO_W-1:0]    tmoCnt_q;

    logic                iGnt_q;
    logic                dGnt_q;
    logic                iRvalid_q;
    logic                dRvalid_q;
    logic [XLEN-1:0]     iRdata_q;
    logic [XLEN-1:0]     dRdata_q;

    logic                memReq_q;
    logic                memWe_q;
    logic [BE_W-1:0]     memBe_q;
    logic [XLEN-1:0]     memAddr_q;
    logic [XLEN-1:0]     memWdata_q;
    logic                busErr_q;

    logic                grantI;
    logic                grantD;

    rv32i_prio_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .i_req_i      (bus.i_req),
        .d_req_i      (bus.d_req),
        .starve_cnt_i (starveCnt_q),
        .grant_i_o    (grantI),
        .grant_d_o    (grantD)
    );

    // Requests are only looked at in IDLE, so a held req cannot be granted twice.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            starveCnt_q <= '0;
            tmoCnt_q    <= '0;
            iGnt_q      <= 1'b0;
            dGnt_q      <= 1'b0;
            iRvalid_q   <= 1'b0;
            dRvalid_q   <= 1'b0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memBe_q     <= '0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            busErr_q    <= 1'b0;
        end else begin
            iGnt_q    <= 1'b0;
            dGnt_q    <= 1'b0;
            iRvalid_q <= 1'b0;
            dRvalid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.mem_rvalid) begin
                        busErr_q <= 1'b1;
                    end
                    if (grantD) begin
                        owner_q     <= OWN_D;
                        dGnt_q      <= 1'b1;
                        memReq_q    <= 1'b1;
                        memWe_q     <= bus.d_we;
                        memBe_q     <= bus.d_be;
                        memAddr_q   <= bus.d_addr;
                        memWdata_q  <= bus.d_wdata;
                        starveCnt_q <= bus.i_req ? starveCnt_q + 1'b1 : '0;
                        state_q     <= ISSUE;
                    end else if (grantI) begin
                        owner_q     <= OWN_I;
                        iGnt_q      <= 1'b1;
                        memReq_q    <= 1'b1;
                        memWe_q     <= 1'b0;
                        memBe_q     <= BE_ALL;
                        memAddr_q   <= bus.i_addr;
                        memWdata_q  <= '0;
                        starveCnt_q <= '0;
                        state_q     <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (bus.mem_rvalid) begin
                        busErr_q <= 1'b1;
                    end
                    if (bus.mem_gnt) begin
                        memReq_q <= 1'b0;
                        tmoCnt_q <= '0;
                        state_q  <= WAIT_RESP;
                    end
                end

                // A real response always beats a timeout expiring in the same cycle.
                WAIT_RESP: begin
                    if (bus.mem_rvalid) begin
                        if (owner_q == OWN_D) begin
                            dRvalid_q <= 1'b1;
                            dRdata_q  <= bus.mem_rdata;
                        end else begin
                            iRvalid_q <= 1'b1;
                            iRdata_q  <= bus.mem_rdata;
                        end
                        state_q <= IDLE;
                    end else if (tmoCnt_q == TMO_W'(TIMEOUT - 1)) begin
                        if (owner_q == OWN_D) begin
                            dRvalid_q <= 1'b1;
                            dRdata_q  <= '0;
                        end else begin
                            iRvalid_q <= 1'b1;
                            iRdata_q  <= '0;
                        end
                        busErr_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_gnt     = iGnt_q;
    assign bus.i_rvalid  = iRvalid_q;
    assign bus.i_rdata   = iRdata_q;
    assign bus.d_gnt     = dGnt_q;
    assign bus.d_rvalid  = dRvalid_q;
    assign bus.d_rdata   = dRdata_q;
    assign bus.mem_req   = memReq_q;
    assign bus.mem_we    = memWe_q;
    assign bus.mem_be    = memBe_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.bus_err   = busErr_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: fetch, store, starvation guard,
// timeout, stray response and mid-transaction reset, with hand-computed results.
module tb_rv32i_mem_arbiter;
    import rv32i_bus_pkg::*;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;

    int compareCount = 0;
    int failCount    = 0;
    int expOrder[6]  = '{1, 1, 1, 1, 0, 1};

    rv32i_mem_arbiter_if bus();

    rv32i_mem_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [6:0] ctlBits;
    assign ctlBits = {bus.mem_req, bus.mem_we, bus.i_gnt, bus.d_gnt,
                      bus.i_rvalid, bus.d_rvalid, bus.bus_err};

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic dReq, input logic dWe,
                                 input logic [3:0] dBe, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata);
        bus.i_req   = iReq;
        bus.i_addr  = iAddr;
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_be    = dBe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
    endtask

    // Returns 1 for a data grant, 0 for a fetch grant, -1 if none within budget.
    task automatic awaitGrant(output int who);
        who = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.d_gnt) begin
                who = 1;
                break;
            end else if (bus.i_gnt) begin
                who = 0;
                break;
            end
        end
    endtask

    // Called in the grant cycle; mem_gnt is high so the next edge accepts.
    task automatic respond(input int delay, input logic [31:0] data);
        step();
        repeat (delay) step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        #1;
        checkOutput({tag, ".ctl"}, {25'd0, ctlBits}, 32'h0);
        checkOutput({tag, ".mem_addr"}, bus.mem_addr, 32'h0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        int   who;
        int   n;
        logic sawLate;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        step();
        step();
        checkOutput("reset.ctl", {25'd0, ctlBits}, 32'h0);
        checkOutput("reset.i_rdata", bus.i_rdata, 32'h0);
        checkOutput("reset.mem_be", {28'd0, bus.mem_be}, 32'h0);
        reset = 1'b0;

        // Single fetch
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        checkOutput("fetch.i_gnt", {31'd0, bus.i_gnt}, 32'h1);
        checkOutput("fetch.d_gnt", {31'd0, bus.d_gnt}, 32'h0);
        checkOutput("fetch.mem_req", {31'd0, bus.mem_req}, 32'h1);
        checkOutput("fetch.mem_addr", bus.mem_addr, 32'h10);
        checkOutput("fetch.mem_be", {28'd0, bus.mem_be}, 32'hF);
        checkOutput("fetch.mem_we", {31'd0, bus.mem_we}, 32'h0);
        checkOutput("fetch.mem_wdata", bus.mem_wdata, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        respond(1, 32'h13);
        checkOutput("fetch.i_rvalid", {31'd0, bus.i_rvalid}, 32'h1);
        checkOutput("fetch.i_rdata", bus.i_rdata, 32'h13);
        checkOutput("fetch.d_rvalid", {31'd0, bus.d_rvalid}, 32'h0);
        step();
        checkOutput("fetch.i_rvalid_pulse", {31'd0, bus.i_rvalid}, 32'h0);
        checkOutput("fetch.i_rdata_hold", bus.i_rdata, 32'h13);

        // Simultaneous requests: store first, then the waiting fetch
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hCAFEBABE);
        awaitGrant(who);
        checkOutput("simul.first", who, 32'd1);
        checkOutput("simul.i_gnt", {31'd0, bus.i_gnt}, 32'h0);
        checkOutput("simul.mem_we", {31'd0, bus.mem_we}, 32'h1);
        checkOutput("simul.mem_be", {28'd0, bus.mem_be}, 32'h3);
        checkOutput("simul.mem_addr", bus.mem_addr, 32'h100);
        checkOutput("simul.mem_wdata", bus.mem_wdata, 32'hCAFEBABE);
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        respond(0, 32'h0);
        checkOutput("simul.d_rvalid", {31'd0, bus.d_rvalid}, 32'h1);
        checkOutput("simul.i_rvalid_d", {31'd0, bus.i_rvalid}, 32'h0);
        awaitGrant(who);
        checkOutput("simul.second", who, 32'd0);
        checkOutput("simul.mem_addr2", bus.mem_addr, 32'h20);
        checkOutput("simul.mem_be2", {28'd0, bus.mem_be}, 32'hF);
        checkOutput("simul.mem_wdata2", bus.mem_wdata, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        respond(0, 32'h93);
        checkOutput("simul.i_rvalid", {31'd0, bus.i_rvalid}, 32'h1);
        checkOutput("simul.i_rdata", bus.i_rdata, 32'h93);
        checkOutput("simul.d_rvalid_i", {31'd0, bus.d_rvalid}, 32'h0);

        // Starvation guard: both held, expect D D D D I D
        applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        for (int k = 0; k < 6; k++) begin
            awaitGrant(who);
            checkOutput($sformatf("starve.grant%0d", k), who, expOrder[k]);
            if (k == 5) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
            respond(0, 32'(k));
        end

        // Timeout after 8 WAIT_RESP cycles
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        awaitGrant(who);
        checkOutput("timeout.grant", who, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            n++;
            if (bus.i_rvalid) break;
        end
        checkOutput("timeout.cycles", n, 32'd8);
        checkOutput("timeout.i_rdata", bus.i_rdata, 32'h0);
        checkOutput("timeout.bus_err", {31'd0, bus.bus_err}, 32'h1);
        checkOutput("timeout.d_rvalid", {31'd0, bus.d_rvalid}, 32'h0);
        repeat (3) step();
        checkOutput("timeout.sticky", {31'd0, bus.bus_err}, 32'h1);

        // Stray response while idle
        doReset("stray.reset");
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        checkOutput("stray.i_rvalid", {31'd0, bus.i_rvalid}, 32'h0);
        checkOutput("stray.d_rvalid", {31'd0, bus.d_rvalid}, 32'h0);
        checkOutput("stray.bus_err", {31'd0, bus.bus_err}, 32'h1);
        checkOutput("stray.i_rdata", bus.i_rdata, 32'h0);
        checkOutput("stray.d_rdata", bus.d_rdata, 32'h0);

        // Reset during WAIT_RESP
        doReset("midrst.pre");
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        awaitGrant(who);
        checkOutput("midrst.grant", who, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        #2;
        doReset("midrst.async");
        sawLate = 1'b0;
        repeat (4) begin
            step();
            if (bus.i_rvalid || bus.d_rvalid) sawLate = 1'b1;
        end
        checkOutput("midrst.no_late_rvalid", {31'd0, sawLate}, 32'h0);
        applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        awaitGrant(who);
        checkOutput("midrst.regrant", who, 32'd0);
        checkOutput("midrst.mem_addr", bus.mem_addr, 32'h84);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        respond(1, 32'h55);
        checkOutput("midrst.i_rvalid", {31'd0, bus.i_rvalid}, 32'h1);
        checkOutput("midrst.i_rdata", bus.i_rdata, 32'h55);
        checkOutput("midrst.bus_err", {31'd0, bus.bus_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one single-port memory bus between the RV32I_Core instruction-fetch port and its load/store port.
- Arbitrates requests with data-over-fetch priority plus a starvation guard, keeps one transaction outstanding, and routes the response back to the port that owns it.
- Adds a response timeout with a sticky error flag.
- Sits between RV32I_Core and the unified instruction/data memory.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while a fetch is pending; range 1..15.
- TIMEOUT, 255: cycles allowed in WAIT_RESP before the arbiter forces a response; range 1..1023.

Ports:
- clk_in  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  32  fetch byte address, word aligned.
- i_gnt  out  1  one-cycle pulse: fetch request accepted.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  32  fetched instruction.
- d_req  in  1  load/store request; held with the d_* fields until d_gnt.
- d_we  in  1  1 = store.
- d_be  in  4  byte enables.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  out  32  load data.
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables; 4'hF for fetches.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data; 0 for fetches.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  memory response valid; also returned for writes.
- mem_rdata  in  32  memory read data.
- bus_err  out  1  sticky: timeout occurred or a stray mem_rvalid was seen.

Behaviour:
- Reset: all outputs are registered and reset to 0; state IDLE; owner = I; starve_cnt = 0; timeout counter = 0. A reset mid-transaction abandons it and delivers no rvalid.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE, arbitration:
  - If d_req and not (i_req and starve_cnt == STARVE_MAX): grant D. starve_cnt increments if i_req is high, otherwise clears.
  - Else if i_req: grant I. starve_cnt clears.
  - On a grant at edge N: latch the request fields into the mem_* registers, set owner, pulse x_gnt during cycle N+1, set mem_req = 1, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: hold mem_req and all mem_* fields stable. When mem_gnt is sampled high: drop mem_req, clear the timeout counter, go to WAIT_RESP. mem_gnt high in the first ISSUE cycle is legal.
- WAIT_RESP:
  - On mem_rvalid: register mem_rdata into the owner's x_rdata and pulse the owner's x_rvalid in the next cycle; go to IDLE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: pulse the owner's x_rvalid with x_rdata = 0, set bus_err, go to IDLE.
- Latency, unloaded bus with mem_gnt = 1 at once and zero-wait memory: req seen at edge 0, gnt and mem_req in cycle 1, WAIT_RESP from cycle 2. A mem_rvalid sampled at edge k gives x_rvalid during cycle k+1. The next arbitration happens on the edge where the arbiter returns to IDLE, so back-to-back grants are at least 3 cycles apart.
- Requests are not re-sampled outside IDLE; a requester may keep req high through its gnt cycle without being granted twice.
- mem_rvalid while in IDLE or ISSUE is ignored, sets bus_err, and produces no x_rvalid.
- x_rdata holds its last value between pulses. Only the owner's rvalid ever pulses.
- Simultaneous mem_rvalid and timeout expiry in the same cycle: mem_rvalid wins and bus_err is not set.

Decomposition:
- Shared package rv32i_bus_pkg holds:
  - state encoding constants (IDLE = 2'd0, ISSUE = 2'd1, WAIT_RESP = 2'd2);
  - owner encoding (OWN_I = 1'b0, OWN_D = 1'b1);
  - the bus width constants.
- One natural sub-module, rv32i_prio_select: combinational priority plus starvation-guard decision that outputs grant_i / grant_d.
- The FSM, field latches and counters stay in the top module.

Test Plan:
- Single fetch: i_req at addr 0x0000_0010; memory returns 0x0000_0013 two cycles after mem_gnt -> one i_gnt pulse; mem_addr = 0x10, mem_be = 4'hF, mem_we = 0; one i_rvalid with i_rdata = 0x0000_0013; d_rvalid stays 0.
- Simultaneous requests: i_req and d_req both high, d_we = 1, d_addr = 0x100, d_wdata = 0xCAFEBABE, d_be = 4'b0011 -> D granted first with those fields on mem_*, then I granted after d_rvalid.
- Starvation guard, STARVE_MAX = 4: d_req and i_req held continuously -> grant order D, D, D, D, I, D…
- Timeout, TIMEOUT = 8: memory never asserts mem_rvalid after mem_gnt -> owner's rvalid pulses with rdata = 0 exactly 8 cycles into WAIT_RESP, and bus_err = 1 stays set.
- Stray response: mem_rvalid pulsed while in IDLE -> no i_rvalid or d_rvalid, bus_err = 1.
- Reset mid-transaction: assert reset during WAIT_RESP -> all outputs go to 0 immediately; after release, a new i_req completes normally with no late rvalid.
